// File: rtl/vischain_if.sv
// Visibility chain bundle: parallel per-link load bus (par_*) plus the serial head stream (m_*).
// Latency: none; this file only carries wires.
// Backpressure: par_ready_o gates each load link; m_ready_i stalls the head stream.
//
// slave  : the chain itself (takes par words, drives the head stream)
// master : the surrounding correlator array / readout side
interface vischain_if #(
    parameter int LENGTH = 4,
    parameter int WIDTH  = 7
);
    localparam int TBITS = $clog2(LENGTH);

    logic [LENGTH-1:0]       par_valid_i;
    logic [LENGTH*WIDTH-1:0] par_rdata_i;
    logic [LENGTH*WIDTH-1:0] par_idata_i;
    logic [LENGTH-1:0]       par_ready_o;
    logic                    m_valid_o;
    logic                    m_ready_i;
    logic [WIDTH-1:0]        m_rdata_o;
    logic [WIDTH-1:0]        m_idata_o;
    logic [TBITS-1:0]        m_tag_o;

    modport slave (
        input  par_valid_i, par_rdata_i, par_idata_i, m_ready_i,
        output par_ready_o, m_valid_o, m_rdata_o, m_idata_o, m_tag_o
    );

    modport master (
        output par_valid_i, par_rdata_i, par_idata_i, m_ready_i,
        input  par_ready_o, m_valid_o, m_rdata_o, m_idata_o, m_tag_o
    );
endinterface

// File: rtl/vischain.sv
// Merges LENGTH parallel visibility results (real/imag + source tag) into one serial stream.
// Latency: a word loaded into link ii reaches m_* after d cycles (d = distance to head), +1 per stall.
// Backpressure: m_ready_i low with head valid freezes the whole chain; par_ready_o flags loss-free loads.
//
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   bus (slave)       : par_valid_i/par_rdata_i/par_idata_i/par_ready_o per link,
//                       m_valid_o/m_ready_i/m_rdata_o/m_idata_o/m_tag_o head stream
//   overflow_o        : sticky, set when any par word or chain word was lost
//   drop_count_o      : saturating count of lost words (only with VISCHAIN_DROP_COUNT_EN)
//
// Optional feature macro: VISCHAIN_DROP_COUNT_EN
module vischain #(
    parameter int LENGTH  = 4,
    parameter int WIDTH   = 7,
    parameter int REVERSE = 1
) (
    input  logic        clock,
    input  logic        reset,
    vischain_if.slave   bus,
    output logic        overflow_o
`ifdef VISCHAIN_DROP_COUNT_EN
    ,
    output logic [15:0] drop_count_o
`endif
);
    localparam int TBITS = $clog2(LENGTH);
    // REVERSE=1 drains toward link 0, REVERSE=0 toward link LENGTH-1.
    localparam int HEAD  = (REVERSE != 0) ? 0 : LENGTH - 1;

    typedef struct packed {
        logic             vld;
        logic [TBITS-1:0] tag;
        logic [WIDTH-1:0] rdat;
        logic [WIDTH-1:0] idat;
    } link_t;

    link_t             link_q [LENGTH];
    link_t             link_d [LENGTH];
    link_t             up     [LENGTH];   // contents of each link's upstream neighbour
    logic [LENGTH-1:0] par_rdy;
    logic [LENGTH-1:0] lost;
    logic              adv;

    // Single global enable: the chain shifts as a whole whenever the head
    // is empty or being accepted. No per-link bubble compaction.
    assign adv = ~link_q[HEAD].vld | bus.m_ready_i;

    for (genvar k = 0; k < LENGTH; k++) begin : g_link
        link_t par_word;

        // The tail link has no upstream; it shifts in an empty slot.
        if (REVERSE != 0) begin : g_up_rev
            if (k == LENGTH - 1) begin : g_tail
                assign up[k] = '0;
            end else begin : g_mid
                assign up[k] = link_q[k+1];
            end
        end else begin : g_up_fwd
            if (k == 0) begin : g_tail
                assign up[k] = '0;
            end else begin : g_mid
                assign up[k] = link_q[k-1];
            end
        end

        assign par_word = '{
            vld:  1'b1,
            tag:  TBITS'(k),
            rdat: bus.par_rdata_i[k*WIDTH +: WIDTH],
            idat: bus.par_idata_i[k*WIDTH +: WIDTH]
        };

        // Shifting: a par load overrides whatever would arrive from upstream.
        // Stalled: a par load only lands in an empty link; occupied links keep their word.
        assign link_d[k] = adv
            ? (bus.par_valid_i[k] ? par_word : up[k])
            : ((bus.par_valid_i[k] && !link_q[k].vld) ? par_word : link_q[k]);

        // A load is loss-free when the slot it lands in would otherwise be
        // empty: the upstream word when shifting, the link itself when stalled.
        assign par_rdy[k] = adv ? ~up[k].vld : ~link_q[k].vld;
    end

    assign lost            = bus.par_valid_i & ~par_rdy;
    assign bus.par_ready_o = par_rdy;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LENGTH; i++) begin
                link_q[i] <= '0;
            end
            overflow_o <= 1'b0;
        end else begin
            for (int i = 0; i < LENGTH; i++) begin
                link_q[i] <= link_d[i];
            end
            if (|lost) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Head stream straight from link registers; par data never reaches m_* in the same cycle.
    assign bus.m_valid_o = link_q[HEAD].vld;
    assign bus.m_rdata_o = link_q[HEAD].rdat;
    assign bus.m_idata_o = link_q[HEAD].idat;
    assign bus.m_tag_o   = link_q[HEAD].tag;

`ifdef VISCHAIN_DROP_COUNT_EN
    localparam int CBITS = $clog2(LENGTH + 1);

    logic [CBITS-1:0] lost_cnt;
    logic [16:0]      drop_sum;

    assign lost_cnt = CBITS'($countones(lost));
    assign drop_sum = {1'b0, drop_count_o} + 17'(lost_cnt);

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count_o <= '0;
        end else begin
            drop_count_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif
endmodule

// File: tb/tb_vischain.sv
// Directed bench for vischain: one DUT draining toward link 0, one toward link LENGTH-1.
// Inputs are driven #1 after the rising edge; outputs are sampled at the same point.
// Every expected value below is hand-derived from the chain behaviour.
module tb_vischain;
    localparam int L = 4;
    localparam int W = 8;

    logic clock;
    logic reset;
    logic ovf1, ovf0;
`ifdef VISCHAIN_DROP_COUNT_EN
    logic [15:0] drop1, drop0;
`endif

    int checks = 0;
    int errors = 0;

    vischain_if #(.LENGTH(L), .WIDTH(W)) if1 ();
    vischain_if #(.LENGTH(L), .WIDTH(W)) if0 ();

    vischain #(.LENGTH(L), .WIDTH(W), .REVERSE(1)) dut1 (
        .clock        (clock),
        .reset        (reset),
        .bus          (if1),
        .overflow_o   (ovf1)
`ifdef VISCHAIN_DROP_COUNT_EN
        ,
        .drop_count_o (drop1)
`endif
    );

    vischain #(.LENGTH(L), .WIDTH(W), .REVERSE(0)) dut0 (
        .clock        (clock),
        .reset        (reset),
        .bus          (if0),
        .overflow_o   (ovf0)
`ifdef VISCHAIN_DROP_COUNT_EN
        ,
        .drop_count_o (drop0)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [18:0] beat(input logic v, input logic [7:0] r,
                                         input logic [7:0] i, input logic [1:0] t);
        return {v, r, i, t};
    endfunction

    function automatic logic [18:0] head1();
        return {if1.m_valid_o, if1.m_rdata_o, if1.m_idata_o, if1.m_tag_o};
    endfunction

    function automatic logic [18:0] head0();
        return {if0.m_valid_o, if0.m_rdata_o, if0.m_idata_o, if0.m_tag_o};
    endfunction

    task automatic test_reset;
        do_reset();
        tick();
        checks++;
        if (head1() !== 19'd0) begin
            errors++;
            $display("FAIL rst_head1: got %h expected %h", head1(), 19'd0);
        end
        checks++;
        if (head0() !== 19'd0) begin
            errors++;
            $display("FAIL rst_head0: got %h expected %h", head0(), 19'd0);
        end
        checks++;
        if (ovf1 !== 1'b0 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_ovf: got %b%b expected 00", ovf1, ovf0);
        end
        checks++;
        if (if1.par_ready_o !== 4'b1111 || if0.par_ready_o !== 4'b1111) begin
            errors++;
            $display("FAIL rst_ready: got %b/%b expected 1111/1111", if1.par_ready_o, if0.par_ready_o);
        end
`ifdef VISCHAIN_DROP_COUNT_EN
        checks++;
        if (drop1 !== 16'd0 || drop0 !== 16'd0) begin
            errors++;
            $display("FAIL rst_drop: got %0d/%0d expected 0/0", drop1, drop0);
        end
`endif
    endtask

    // All four links load at once into an empty chain, head is link 0.
    task automatic test_forward;
        logic [18:0] exp_b;
        do_reset();
        if1.m_ready_i   = 1'b1;
        if1.par_valid_i = 4'b1111;
        if1.par_rdata_i = {8'd40, 8'd30, 8'd20, 8'd10};
        if1.par_idata_i = {8'd41, 8'd31, 8'd21, 8'd11};
        checks++;
        if (if1.par_ready_o !== 4'b1111) begin
            errors++;
            $display("FAIL fwd_ready: got %b expected 1111", if1.par_ready_o);
        end
        tick();
        if1.par_valid_i = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            exp_b = beat(1'b1, 8'(10 * (b + 1)), 8'(10 * (b + 1) + 1), 2'(b));
            checks++;
            if (head1() !== exp_b) begin
                errors++;
                $display("FAIL fwd_beat%0d: got %h expected %h", b, head1(), exp_b);
            end
            tick();
        end
        checks++;
        if (if1.m_valid_o !== 1'b0 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL fwd_end: got valid=%b ovf=%b expected valid=0 ovf=0", if1.m_valid_o, ovf1);
        end
    endtask

    // Same stimulus on the chain that drains toward link 3.
    task automatic test_reverse0;
        logic [18:0] exp_b;
        if0.m_ready_i   = 1'b1;
        if0.par_valid_i = 4'b1111;
        if0.par_rdata_i = {8'd40, 8'd30, 8'd20, 8'd10};
        if0.par_idata_i = {8'd41, 8'd31, 8'd21, 8'd11};
        tick();
        if0.par_valid_i = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            exp_b = beat(1'b1, 8'(40 - 10 * b), 8'(41 - 10 * b), 2'(3 - b));
            checks++;
            if (head0() !== exp_b) begin
                errors++;
                $display("FAIL rev0_beat%0d: got %h expected %h", b, head0(), exp_b);
            end
            tick();
        end
        checks++;
        if (if0.m_valid_o !== 1'b0 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL rev0_end: got valid=%b ovf=%b expected valid=0 ovf=0", if0.m_valid_o, ovf0);
        end
    endtask

    // Head held under backpressure; a load into an empty link is accepted.
    task automatic test_stall;
        do_reset();
        if1.m_ready_i   = 1'b0;
        if1.par_valid_i = 4'b0001;
        if1.par_rdata_i = {8'd0, 8'd50, 8'd0, 8'd10};
        if1.par_idata_i = {8'd0, 8'd51, 8'd0, 8'd11};
        tick();
        if1.par_valid_i = 4'b0100;
        checks++;
        if (if1.par_ready_o !== 4'b1110) begin
            errors++;
            $display("FAIL stall_ready: got %b expected 1110", if1.par_ready_o);
        end
        tick();
        if1.par_valid_i = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (head1() !== beat(1'b1, 8'd10, 8'd11, 2'd0)) begin
                errors++;
                $display("FAIL stall_hold%0d: got %h expected %h", c, head1(), beat(1'b1, 8'd10, 8'd11, 2'd0));
            end
            tick();
        end
        if1.m_ready_i = 1'b1;
        checks++;
        if (head1() !== beat(1'b1, 8'd10, 8'd11, 2'd0)) begin
            errors++;
            $display("FAIL stall_rel0: got %h expected %h", head1(), beat(1'b1, 8'd10, 8'd11, 2'd0));
        end
        tick();
        // link 2 word is one link away from the head after the first shift
        checks++;
        if (if1.m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_bubble: got valid=%b expected 0", if1.m_valid_o);
        end
        tick();
        checks++;
        if (head1() !== beat(1'b1, 8'd50, 8'd51, 2'd2)) begin
            errors++;
            $display("FAIL stall_rel1: got %h expected %h", head1(), beat(1'b1, 8'd50, 8'd51, 2'd2));
        end
        tick();
        checks++;
        if (if1.m_valid_o !== 1'b0 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL stall_end: got valid=%b ovf=%b expected valid=0 ovf=0", if1.m_valid_o, ovf1);
        end
    endtask

    // Load into an occupied link while stalled: par word dropped.
    task automatic test_overflow_stall;
        do_reset();
        if1.m_ready_i   = 1'b0;
        if1.par_valid_i = 4'b0011;
        if1.par_rdata_i = {8'd0, 8'd0, 8'd20, 8'd10};
        if1.par_idata_i = {8'd0, 8'd0, 8'd21, 8'd11};
        tick();
        checks++;
        if (if1.par_ready_o !== 4'b1100) begin
            errors++;
            $display("FAIL ovs_ready: got %b expected 1100", if1.par_ready_o);
        end
        if1.par_valid_i = 4'b0010;
        if1.par_rdata_i = {8'd0, 8'd0, 8'd99, 8'd0};
        if1.par_idata_i = {8'd0, 8'd0, 8'd98, 8'd0};
        checks++;
        if (ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL ovs_pre: got %b expected 0", ovf1);
        end
        tick();
        if1.par_valid_i = 4'b0000;
        checks++;
        if (ovf1 !== 1'b1) begin
            errors++;
            $display("FAIL ovs_set: got %b expected 1", ovf1);
        end
`ifdef VISCHAIN_DROP_COUNT_EN
        checks++;
        if (drop1 !== 16'd1) begin
            errors++;
            $display("FAIL ovs_drop: got %0d expected 1", drop1);
        end
`endif
        tick();
        tick();
        if1.m_ready_i = 1'b1;
        checks++;
        if (head1() !== beat(1'b1, 8'd10, 8'd11, 2'd0)) begin
            errors++;
            $display("FAIL ovs_beat0: got %h expected %h", head1(), beat(1'b1, 8'd10, 8'd11, 2'd0));
        end
        tick();
        checks++;
        if (head1() !== beat(1'b1, 8'd20, 8'd21, 2'd1)) begin
            errors++;
            $display("FAIL ovs_beat1: got %h expected %h", head1(), beat(1'b1, 8'd20, 8'd21, 2'd1));
        end
        tick();
        checks++;
        if (if1.m_valid_o !== 1'b0 || ovf1 !== 1'b1) begin
            errors++;
            $display("FAIL ovs_sticky: got valid=%b ovf=%b expected valid=0 ovf=1", if1.m_valid_o, ovf1);
        end
    endtask

    // Shifting chain: par load at link 1 overwrites the word coming from link 2.
    task automatic test_overflow_adv;
        do_reset();
        if1.m_ready_i   = 1'b1;
        if1.par_valid_i = 4'b0100;
        if1.par_rdata_i = {8'd0, 8'd30, 8'd0, 8'd0};
        if1.par_idata_i = {8'd0, 8'd31, 8'd0, 8'd0};
        tick();
        if1.par_valid_i = 4'b0010;
        if1.par_rdata_i = {8'd0, 8'd0, 8'd20, 8'd0};
        if1.par_idata_i = {8'd0, 8'd0, 8'd21, 8'd0};
        checks++;
        if (if1.par_ready_o !== 4'b1101) begin
            errors++;
            $display("FAIL ova_ready: got %b expected 1101", if1.par_ready_o);
        end
        tick();
        if1.par_valid_i = 4'b0000;
        checks++;
        if (ovf1 !== 1'b1) begin
            errors++;
            $display("FAIL ova_set: got %b expected 1", ovf1);
        end
`ifdef VISCHAIN_DROP_COUNT_EN
        checks++;
        if (drop1 !== 16'd1) begin
            errors++;
            $display("FAIL ova_drop: got %0d expected 1", drop1);
        end
`endif
        tick();
        checks++;
        if (head1() !== beat(1'b1, 8'd20, 8'd21, 2'd1)) begin
            errors++;
            $display("FAIL ova_beat: got %h expected %h", head1(), beat(1'b1, 8'd20, 8'd21, 2'd1));
        end
        tick();
        checks++;
        if (if1.m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL ova_lost: got valid=%b expected 0", if1.m_valid_o);
        end
    endtask

    // Reset with words in flight; loads presented during reset are ignored.
    task automatic test_reset_mid;
        if1.m_ready_i   = 1'b1;
        if1.par_valid_i = 4'b0111;
        if1.par_rdata_i = {8'd0, 8'd30, 8'd20, 8'd10};
        if1.par_idata_i = {8'd0, 8'd31, 8'd21, 8'd11};
        tick();
        if1.par_valid_i = 4'b1111;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if1.par_valid_i = 4'b0000;
        checks++;
        if (head1() !== 19'd0) begin
            errors++;
            $display("FAIL rmid_head: got %h expected %h", head1(), 19'd0);
        end
        checks++;
        if (ovf1 !== 1'b0 || if1.par_ready_o !== 4'b1111) begin
            errors++;
            $display("FAIL rmid_state: got ovf=%b ready=%b expected ovf=0 ready=1111", ovf1, if1.par_ready_o);
        end
`ifdef VISCHAIN_DROP_COUNT_EN
        checks++;
        if (drop1 !== 16'd0) begin
            errors++;
            $display("FAIL rmid_drop: got %0d expected 0", drop1);
        end
`endif
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (if1.m_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL rmid_quiet%0d: got valid=%b expected 0", c, if1.m_valid_o);
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        if1.par_valid_i = '0;
        if1.par_rdata_i = '0;
        if1.par_idata_i = '0;
        if1.m_ready_i   = 1'b1;
        if0.par_valid_i = '0;
        if0.par_rdata_i = '0;
        if0.par_idata_i = '0;
        if0.m_ready_i   = 1'b1;

        test_reset();
        test_forward();
        test_reverse0();
        test_stall();
        test_overflow_stall();
        test_overflow_adv();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
